io_interrupt_ctrl: RTL and testbench

//  Sequences the 8-bit input (INPR) and output (OUTR) eightbitregister instances of the basic computer.

---
 rtl/io_pkg.sv | 23 ++
 rtl/io_interrupt_ctrl_if.sv | 38 +++
 rtl/io_interrupt_ctrl_printer.sv | 37 +++
 rtl/io_interrupt_ctrl.sv | 88 ++++++++
 tb/tb_io_interrupt_ctrl.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/io_pkg.sv
// Shared constants for the basic-computer I/O and interrupt controller:
// command bit positions, printer port state encodings and width defaults.
package io_pkg;

  localparam int unsigned DATA_W_DFLT = 8;
  localparam int unsigned BUS_W_DFLT  = 16;

  // io_cmd carries IR[11:6]; bit 5 is INP down to bit 0 IOF
  localparam int unsigned CMD_INP = 5;
  localparam int unsigned CMD_OUT = 4;
  localparam int unsigned CMD_SKI = 3;
  localparam int unsigned CMD_SKO = 2;
  localparam int unsigned CMD_ION = 1;
  localparam int unsigned CMD_IOF = 0;

  localparam logic [0:0] PRN_IDLE = 1'b0;
  localparam logic [0:0] PRN_SEND = 1'b1;

  function automatic logic is_onehot6(input logic [5:0] v);
    return (v != '0) && ((v & (v - 6'd1)) == '0);
  endfunction

endpackage

// File: rtl/io_interrupt_ctrl_if.sv
// Keyboard, printer and control-unit signals of the I/O controller.
// master = the controller itself, slave = the surrounding datapath/devices.
interface io_interrupt_ctrl_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned BUS_W  = 16
);
  logic              kbd_valid;
  logic [DATA_W-1:0] kbd_data;
  logic              kbd_ready;
  logic              inpr_load;
  logic [BUS_W-1:0]  inpr_data;
  logic              outr_load;
  logic              ac_load_inpr;
  logic              prn_valid;
  logic              prn_ready;
  logic              io_exec;
  logic [5:0]        io_cmd;
  logic              instr_end;
  logic              int_ack;
  logic              skip;
  logic              fgi;
  logic              fgo;
  logic              ien;
  logic              r;
  logic              io_err;

  modport master (
    input  kbd_valid, kbd_data, prn_ready, io_exec, io_cmd, instr_end, int_ack,
    output kbd_ready, inpr_load, inpr_data, outr_load, ac_load_inpr, prn_valid,
           skip, fgi, fgo, ien, r, io_err
  );

  modport slave (
    output kbd_valid, kbd_data, prn_ready, io_exec, io_cmd, instr_end, int_ack,
    input  kbd_ready, inpr_load, inpr_data, outr_load, ac_load_inpr, prn_valid,
           skip, fgi, fgo, ien, r, io_err
  );
endinterface

// File: rtl/io_interrupt_ctrl_printer.sv
// Printer side of OUTR: IDLE/SEND handshake, prn_valid register and the
// done pulse that hands the FGO flag back to the CPU.
module printer_port_fsm
  import io_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  input  logic i_prn_ready,
  output logic o_prn_valid,
  output logic o_done
);

  logic [0:0] r_state;
  logic       r_prn_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= PRN_IDLE;
      r_prn_valid <= 1'b0;
    end else if (r_state == PRN_IDLE) begin
      if (i_start) begin
        r_state     <= PRN_SEND;
        r_prn_valid <= 1'b1;
      end
    end else begin
      if (i_prn_ready) begin
        r_state     <= PRN_IDLE;
        r_prn_valid <= 1'b0;
      end
    end
  end

  assign o_prn_valid = r_prn_valid;
  assign o_done      = (r_state == PRN_SEND) & i_prn_ready;

endmodule

// File: rtl/io_interrupt_ctrl.sv
// I/O and interrupt controller of the basic computer: FGI/FGO/IEN/R flags,
// INP/OUT/SKI/SKO/ION/IOF execution and the INPR/OUTR load strobes.
module io_interrupt_ctrl
  import io_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DFLT,
  parameter int unsigned BUS_W  = BUS_W_DFLT
) (
  input  logic                clk,
  input  logic                rst,
  io_interrupt_ctrl_if.master bus
);

  logic r_fgi;
  logic r_fgo;
  logic r_ien;
  logic r_r;

  logic w_legal;
  logic w_inp;
  logic w_out;
  logic w_ski;
  logic w_sko;
  logic w_ion;
  logic w_iof;
  logic w_kbd_take;
  logic w_out_go;
  logic w_prn_done;
  logic w_prn_valid;

  assign w_legal = bus.io_exec & is_onehot6(bus.io_cmd);
  assign w_inp   = w_legal & bus.io_cmd[CMD_INP];
  assign w_out   = w_legal & bus.io_cmd[CMD_OUT];
  assign w_ski   = w_legal & bus.io_cmd[CMD_SKI];
  assign w_sko   = w_legal & bus.io_cmd[CMD_SKO];
  assign w_ion   = w_legal & bus.io_cmd[CMD_ION];
  assign w_iof   = w_legal & bus.io_cmd[CMD_IOF];

  assign w_kbd_take = bus.kbd_valid & ~r_fgi;
  assign w_out_go   = w_out & r_fgo;

  printer_port_fsm u_prn (
    .clk         (clk),
    .rst         (rst),
    .i_start     (w_out_go),
    .i_prn_ready (bus.prn_ready),
    .o_prn_valid (w_prn_valid),
    .o_done      (w_prn_done)
  );

  // A keyboard accept in the INP cycle wins; AC still latches the old INPR.
  // OUT needs fgo=1 and done only fires in SEND (fgo=0), so they never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fgi <= 1'b0;
      r_fgo <= 1'b1;
      r_ien <= 1'b0;
      r_r   <= 1'b0;
    end else begin
      if (w_kbd_take)      r_fgi <= 1'b1;
      else if (w_inp)      r_fgi <= 1'b0;

      if (w_out_go)        r_fgo <= 1'b0;
      else if (w_prn_done) r_fgo <= 1'b1;

      if (bus.int_ack)     r_ien <= 1'b0;
      else if (w_ion)      r_ien <= 1'b1;
      else if (w_iof)      r_ien <= 1'b0;

      if (bus.int_ack)                                    r_r <= 1'b0;
      else if (bus.instr_end & r_ien & (r_fgi | r_fgo))   r_r <= 1'b1;
    end
  end

  assign bus.kbd_ready    = ~r_fgi;
  assign bus.inpr_load    = w_kbd_take;
  assign bus.inpr_data    = {{(BUS_W-DATA_W){1'b0}}, bus.kbd_data};
  assign bus.outr_load    = w_out_go;
  assign bus.ac_load_inpr = w_inp;
  assign bus.prn_valid    = w_prn_valid;
  assign bus.skip         = (w_ski & r_fgi) | (w_sko & r_fgo);
  assign bus.fgi          = r_fgi;
  assign bus.fgo          = r_fgo;
  assign bus.ien          = r_ien;
  assign bus.r            = r_r;
  assign bus.io_err       = (bus.io_exec & ~is_onehot6(bus.io_cmd)) | (w_out & ~r_fgo);

endmodule

// File: tb/tb_io_interrupt_ctrl.sv
// Scoreboard bench for io_interrupt_ctrl: directed stimulus queues expected
// per-cycle snapshots and keyboard loads; a negedge monitor pops and compares.
module tb_io_interrupt_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  io_interrupt_ctrl_if #(.DATA_W(8), .BUS_W(16)) bus ();

  io_interrupt_ctrl #(.DATA_W(8), .BUS_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          cyc;
    string       name;
    logic [10:0] v;
  } exp_t;

  exp_t       q_exp[$];
  logic [7:0] q_kbd[$];
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Snapshot order: kbd_ready inpr_load outr_load ac_load_inpr prn_valid skip fgi fgo ien r io_err
  function automatic logic [10:0] E(input bit krdy, ild, old, acl, pv, skp, fgi, fgo, ien, r, err);
    return {krdy, ild, old, acl, pv, skp, fgi, fgo, ien, r, err};
  endfunction

  function automatic logic [10:0] snap();
    return {bus.kbd_ready, bus.inpr_load, bus.outr_load, bus.ac_load_inpr, bus.prn_valid,
            bus.skip, bus.fgi, bus.fgo, bus.ien, bus.r, bus.io_err};
  endfunction

  task automatic ex(input string name, input logic [10:0] v);
    exp_t e;
    e.cyc = cyc; e.name = name; e.v = v;
    q_exp.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exec(input logic [5:0] cmd);
    bus.io_exec = 1'b1;
    bus.io_cmd  = cmd;
  endtask

  // Monitor: snapshot checks due this cycle, plus every INPR load strobe
  always @(negedge clk) begin
    logic [10:0] got;
    logic [7:0]  kd;
    got = snap();
    while (q_exp.size() != 0 && q_exp[0].cyc <= cyc) begin
      exp_t e;
      e = q_exp.pop_front();
      total++;
      if (e.cyc < cyc) begin
        bad++;
        $display("FAIL %s: check missed (due cycle %0d, now %0d)", e.name, e.cyc, cyc);
      end else if (got !== e.v) begin
        bad++;
        $display("FAIL %s: got=%b exp=%b (krdy ild old acl pv skp fgi fgo ien r err)", e.name, got, e.v);
      end
    end
    if (bus.inpr_load === 1'b1) begin
      total++;
      if (q_kbd.size() == 0) begin
        bad++;
        $display("FAIL inpr_load: unexpected load, inpr_data=%h", bus.inpr_data);
      end else begin
        kd = q_kbd.pop_front();
        if (bus.inpr_data !== {8'h00, kd}) begin
          bad++;
          $display("FAIL inpr_data: got=%h exp=%h", bus.inpr_data, {8'h00, kd});
        end
      end
    end
  end

  initial begin
    rst           = 1'b1;
    bus.kbd_valid = 1'b0;
    bus.kbd_data  = '0;
    bus.prn_ready = 1'b0;
    bus.io_exec   = 1'b0;
    bus.io_cmd    = '0;
    bus.instr_end = 1'b0;
    bus.int_ack   = 1'b0;

    // T1 reset
    step(); step();
    rst = 1'b0;
    ex("reset", E(1,0,0,0,0,0, 0,1,0,0, 0));

    // T2 keyboard accept, zero-latency load
    step();
    bus.kbd_valid = 1'b1; bus.kbd_data = 8'h41;
    q_kbd.push_back(8'h41);
    ex("kbd_accept", E(1,1,0,0,0,0, 0,1,0,0, 0));

    // T3 second character held while fgi=1
    step();
    bus.kbd_data = 8'h42;
    ex("kbd_hold1", E(0,0,0,0,0,0, 1,1,0,0, 0));
    step();
    ex("kbd_hold2", E(0,0,0,0,0,0, 1,1,0,0, 0));
    step();
    exec(6'b100000);
    ex("inp", E(0,0,0,1,0,0, 1,1,0,0, 0));
    step();
    bus.io_exec = 1'b0;
    q_kbd.push_back(8'h42);
    ex("kbd_after_inp", E(1,1,0,0,0,0, 0,1,0,0, 0));
    step();
    bus.kbd_valid = 1'b0;
    ex("fgi_set2", E(0,0,0,0,0,0, 1,1,0,0, 0));

    // T4 printer with delayed prn_ready; T5 commands issued during SEND
    step();
    exec(6'b010000);
    ex("out", E(0,0,1,0,0,0, 1,1,0,0, 0));
    step();
    bus.io_exec = 1'b0;
    ex("send", E(0,0,0,0,1,0, 1,0,0,0, 0));
    step();
    exec(6'b010000);
    ex("out_in_send", E(0,0,0,0,1,0, 1,0,0,0, 1));
    step();
    exec(6'b000100);
    ex("sko_fgo0", E(0,0,0,0,1,0, 1,0,0,0, 0));
    step();
    exec(6'b001000);
    ex("ski_fgi1", E(0,0,0,0,1,1, 1,0,0,0, 0));
    step();
    exec(6'b110000);
    ex("not_onehot", E(0,0,0,0,1,0, 1,0,0,0, 1));
    step();
    bus.io_exec = 1'b0; bus.prn_ready = 1'b1;
    ex("handshake", E(0,0,0,0,1,0, 1,0,0,0, 0));
    step();
    bus.prn_ready = 1'b0;
    ex("fgo_back", E(0,0,0,0,0,0, 1,1,0,0, 0));

    // T6 interrupt: ION with instr_end uses the old ien
    step();
    exec(6'b000010); bus.instr_end = 1'b1;
    ex("ion_endi", E(0,0,0,0,0,0, 1,1,0,0, 0));
    step();
    bus.io_exec = 1'b0;
    ex("ion_pre_ien", E(0,0,0,0,0,0, 1,1,1,0, 0));
    step();
    bus.instr_end = 1'b0;
    ex("r_set", E(0,0,0,0,0,0, 1,1,1,1, 0));
    step();
    exec(6'b000010); bus.int_ack = 1'b1; bus.instr_end = 1'b1;
    ex("ack_cycle", E(0,0,0,0,0,0, 1,1,1,1, 0));
    step();
    bus.io_exec = 1'b0; bus.int_ack = 1'b0; bus.instr_end = 1'b0;
    ex("ack_wins", E(0,0,0,0,0,0, 1,1,0,0, 0));
    step();
    exec(6'b000010);
    ex("ion", E(0,0,0,0,0,0, 1,1,0,0, 0));
    step();
    exec(6'b000001);
    ex("iof", E(0,0,0,0,0,0, 1,1,1,0, 0));
    step();
    bus.io_exec = 1'b0;
    ex("iof_done", E(0,0,0,0,0,0, 1,1,0,0, 0));

    // Reset while the printer is in SEND drops the transfer
    step();
    exec(6'b010000);
    ex("out2", E(0,0,1,0,0,0, 1,1,0,0, 0));
    step();
    bus.io_exec = 1'b0; rst = 1'b1;
    ex("send2", E(0,0,0,0,1,0, 1,0,0,0, 0));
    step();
    rst = 1'b0;
    ex("rst_in_send", E(1,0,0,0,0,0, 0,1,0,0, 0));

    // INP with fgi=0 together with a keyboard accept: set wins
    step();
    exec(6'b100000); bus.kbd_valid = 1'b1; bus.kbd_data = 8'h43;
    q_kbd.push_back(8'h43);
    ex("inp_and_kbd", E(1,1,0,1,0,0, 0,1,0,0, 0));
    step();
    bus.io_exec = 1'b0; bus.kbd_valid = 1'b0;
    ex("set_wins", E(0,0,0,0,0,0, 1,1,0,0, 0));

    // io_cmd is ignored without io_exec
    step();
    bus.io_cmd = 6'b110000;
    ex("no_exec", E(0,0,0,0,0,0, 1,1,0,0, 0));

    step(); step();
    if (q_exp.size() != 0 || q_kbd.size() != 0) begin
      total++; bad++;
      $display("FAIL leftover: exp=%0d kbd=%0d required 0 and 0", q_exp.size(), q_kbd.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
